// File: rtl/fir_serial_mac_scheduler_if.sv
// Handshake and operand bus between the FIR MAC scheduler and its surroundings
// (sample sources, coefficient writer, shared MAC datapath, result consumer).
interface fir_serial_mac_scheduler_if #(
  parameter int unsigned N_CH   = 2,
  parameter int unsigned CNT_W  = 3,
  parameter int unsigned CH_W   = 1,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ACC_W  = 33
);
  logic [N_CH-1:0]        in_valid;
  logic [N_CH*DATA_W-1:0] in_data;
  logic [N_CH-1:0]        in_ready;
  logic                   coef_we;
  logic [CNT_W-1:0]       coef_addr;
  logic [DATA_W-1:0]      coef_data;
  logic                   coef_busy;
  logic                   mac_valid;
  logic                   mac_first;
  logic                   mac_last;
  logic [DATA_W-1:0]      mac_sample;
  logic [DATA_W-1:0]      mac_coeff;
  logic [ACC_W-1:0]       acc_in;
  logic                   out_valid;
  logic                   out_ready;
  logic [CH_W-1:0]        out_ch;
  logic [ACC_W-1:0]       out_data;

  modport slave (
    input  in_valid, in_data, coef_we, coef_addr, coef_data, acc_in, out_ready,
    output in_ready, coef_busy, mac_valid, mac_first, mac_last, mac_sample, mac_coeff,
           out_valid, out_ch, out_data
  );

  modport master (
    output in_valid, in_data, coef_we, coef_addr, coef_data, acc_in, out_ready,
    input  in_ready, coef_busy, mac_valid, mac_first, mac_last, mac_sample, mac_coeff,
           out_valid, out_ch, out_data
  );
endinterface

// File: rtl/fir_serial_mac_scheduler.sv
// Round-robin scheduler sharing one serial MAC datapath among N_CH FIR channels:
// per-channel delay lines, one shared coefficient bank, registered result output.
module fir_serial_mac_scheduler #(
  parameter int unsigned N_CH   = 2,
  parameter int unsigned TAPS   = 8,
  parameter int unsigned CNT_W  = 3,
  parameter int unsigned CH_W   = 1,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ACC_W  = 33
) (
  input logic                         clk,
  input logic                         reset,
  input logic                         clk_enable,
  fir_serial_mac_scheduler_if.slave   bus
);

  typedef enum logic [1:0] {StIdle, StRun, StCapture} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   tap_q, tap_d;
  logic [CH_W-1:0]    rr_q, rr_d;
  logic [CH_W-1:0]    cur_ch_q, cur_ch_d;
  logic [DATA_W-1:0]  dl_q [N_CH][TAPS];
  logic [DATA_W-1:0]  dl_d [N_CH][TAPS];
  logic [DATA_W-1:0]  coef_q [TAPS];
  logic [DATA_W-1:0]  coef_d [TAPS];
  logic               out_valid_q, out_valid_d;
  logic [CH_W-1:0]    out_ch_q, out_ch_d;
  logic [ACC_W-1:0]   out_data_q, out_data_d;

  logic               grant_any;
  logic [CH_W-1:0]    grant_idx;
  logic [CH_W-1:0]    idx;
  logic               accept;
  logic               run;

  // Search starts one past the last granted channel so every requester gets a turn.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    idx       = '0;
    for (int i = 1; i <= int'(N_CH); i++) begin
      idx = CH_W'((int'(rr_q) + i) % int'(N_CH));
      if (!grant_any && bus.in_valid[idx]) begin
        grant_any = 1'b1;
        grant_idx = idx;
      end
    end
  end

  assign accept = clk_enable && (state_q == StIdle) && !bus.coef_we && grant_any &&
                  (!out_valid_q || bus.out_ready);

  always_comb begin
    bus.in_ready = '0;
    if (accept) bus.in_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    tap_d      = tap_q;
    rr_d       = rr_q;
    cur_ch_d   = cur_ch_q;
    dl_d       = dl_q;
    coef_d     = coef_q;
    out_valid_d = out_valid_q;
    out_ch_d   = out_ch_q;
    out_data_d = out_data_q;

    if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;

    case (state_q)
      StIdle: begin
        if (bus.coef_we) begin
          coef_d[bus.coef_addr] = bus.coef_data;
        end else if (accept) begin
          for (int k = TAPS - 1; k > 0; k--) dl_d[grant_idx][k] = dl_q[grant_idx][k-1];
          dl_d[grant_idx][0] = bus.in_data[grant_idx*DATA_W +: DATA_W];
          rr_d     = grant_idx;
          cur_ch_d = grant_idx;
          state_d  = StRun;
        end
      end
      StRun: begin
        tap_d = tap_q + CNT_W'(1);
        if (tap_q == CNT_W'(TAPS - 1)) state_d = StCapture;
      end
      StCapture: begin
        // A capture on the same edge as a consumer handshake reloads the register.
        out_valid_d = 1'b1;
        out_data_d  = bus.acc_in;
        out_ch_d    = cur_ch_q;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      tap_q       <= '0;
      rr_q        <= CH_W'(N_CH - 1);
      cur_ch_q    <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_data_q  <= '0;
      for (int c = 0; c < int'(N_CH); c++) begin
        for (int k = 0; k < int'(TAPS); k++) dl_q[c][k] <= '0;
      end
      for (int k = 0; k < int'(TAPS); k++) coef_q[k] <= '0;
    end else if (clk_enable) begin
      state_q     <= state_d;
      tap_q       <= tap_d;
      rr_q        <= rr_d;
      cur_ch_q    <= cur_ch_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      out_data_q  <= out_data_d;
      dl_q        <= dl_d;
      coef_q      <= coef_d;
    end
  end

  assign run            = clk_enable && (state_q == StRun);
  assign bus.mac_valid  = run;
  assign bus.mac_first  = run && (tap_q == '0);
  assign bus.mac_last   = run && (tap_q == CNT_W'(TAPS - 1));
  assign bus.mac_sample = run ? dl_q[cur_ch_q][tap_q] : '0;
  assign bus.mac_coeff  = run ? coef_q[tap_q] : '0;
  assign bus.coef_busy  = (state_q != StIdle);
  assign bus.out_valid  = out_valid_q;
  assign bus.out_ch     = out_ch_q;
  assign bus.out_data   = out_data_q;

endmodule

// File: tb/tb_fir_serial_mac_scheduler.sv
// Bench for fir_serial_mac_scheduler: exact MAC datapath model, a cycle-level
// behavioural reference checked every cycle, directed corner cases and random traffic.
module tb_fir_serial_mac_scheduler;
  localparam int N_CH = 2;
  localparam int TAPS = 8;
  localparam int CNT_W = 3;
  localparam int CH_W = 1;
  localparam int DW = 16;
  localparam int AW = 33;

  logic clk = 1'b0;
  logic reset;
  logic clk_enable;
  always #5 clk = ~clk;

  fir_serial_mac_scheduler_if #(
    .N_CH(N_CH), .CNT_W(CNT_W), .CH_W(CH_W), .DATA_W(DW), .ACC_W(AW)
  ) bus ();

  fir_serial_mac_scheduler #(
    .N_CH(N_CH), .TAPS(TAPS), .CNT_W(CNT_W), .CH_W(CH_W), .DATA_W(DW), .ACC_W(AW)
  ) dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .bus(bus)
  );

  function automatic longint prod(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return longint'($signed(a)) * longint'($signed(b));
  endfunction

  // Shared MAC datapath: load on first tap, accumulate otherwise.
  logic [AW-1:0] acc = '0;
  always @(posedge clk) begin
    if (bus.mac_valid)
      acc <= bus.mac_first ? AW'(prod(bus.mac_sample, bus.mac_coeff))
                           : acc + AW'(prod(bus.mac_sample, bus.mac_coeff));
  end
  assign bus.acc_in = acc;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_hs = 0;

  // Reference model state
  logic [DW-1:0] hist [N_CH][TAPS];
  logic [DW-1:0] coef_m [TAPS];
  int            busy_cnt;
  int            rr_m;
  int            cur_m;
  bit            ov_m;
  logic [AW-1:0] exp_data;
  int            exp_ch;
  logic [AW-1:0] pend_data;

  // Last observed DUT outputs, used only to steer directed sequences
  logic [N_CH-1:0] obs_rdy;
  logic            obs_ov, obs_first, obs_last, obs_mac, obs_busy;
  logic [DW-1:0]   obs_coeff;
  logic [AW-1:0]   obs_data;
  logic [CH_W-1:0] obs_ch;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < N_CH; c++)
      for (int k = 0; k < TAPS; k++) hist[c][k] = '0;
    for (int k = 0; k < TAPS; k++) coef_m[k] = '0;
    busy_cnt = 0;
    rr_m = N_CH - 1;
    cur_m = 0;
    ov_m = 0;
    exp_data = '0;
    exp_ch = 0;
    pend_data = '0;
  endtask

  function automatic longint filt(input int ch);
    longint s = 0;
    for (int k = 0; k < TAPS; k++) s += prod(hist[ch][k], coef_m[k]);
    return s;
  endfunction

  // One clock cycle: observe and check at negedge+1, advance the model, wait for next negedge.
  task automatic step();
    int exp_g;
    int k;
    bit mac_on;
    logic [N_CH-1:0] exp_rdy;
    #1;
    cyc++;
    obs_rdy = bus.in_ready; obs_ov = bus.out_valid; obs_first = bus.mac_first;
    obs_last = bus.mac_last; obs_mac = bus.mac_valid; obs_busy = bus.coef_busy;
    obs_coeff = bus.mac_coeff; obs_data = bus.out_data; obs_ch = bus.out_ch;
    if (reset) begin
      model_reset();
    end else begin
      exp_g = -1;
      if (clk_enable && busy_cnt == 0 && !bus.coef_we && (!ov_m || bus.out_ready))
        for (int i = 1; i <= N_CH; i++)
          if (exp_g < 0 && bus.in_valid[(rr_m + i) % N_CH]) exp_g = (rr_m + i) % N_CH;
      exp_rdy = '0;
      if (exp_g >= 0) exp_rdy[exp_g] = 1'b1;
      chk("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
      chk("coef_busy", 64'(bus.coef_busy), 64'(busy_cnt != 0));
      mac_on = clk_enable && busy_cnt >= 2;
      k = TAPS + 1 - busy_cnt;
      chk("mac_valid", 64'(bus.mac_valid), 64'(mac_on));
      chk("mac_first", 64'(bus.mac_first), 64'(mac_on && k == 0));
      chk("mac_last", 64'(bus.mac_last), 64'(mac_on && k == TAPS - 1));
      if (mac_on) begin
        chk("mac_sample", 64'(bus.mac_sample), 64'(hist[cur_m][k]));
        chk("mac_coeff", 64'(bus.mac_coeff), 64'(coef_m[k]));
      end
      chk("out_valid", 64'(bus.out_valid), 64'(ov_m));
      if (ov_m) begin
        chk("out_data", 64'(bus.out_data), 64'(exp_data));
        chk("out_ch", 64'(bus.out_ch), 64'(exp_ch));
      end
      if (clk_enable) begin
        if (ov_m && bus.out_ready) begin
          ov_m = 0;
          n_hs++;
        end
        if (busy_cnt == 1) begin
          ov_m = 1;
          exp_data = pend_data;
          exp_ch = cur_m;
        end
        if (busy_cnt > 0) busy_cnt--;
        else if (bus.coef_we) coef_m[bus.coef_addr] = bus.coef_data;
        else if (exp_g >= 0) begin
          for (int j = TAPS - 1; j > 0; j--) hist[exp_g][j] = hist[exp_g][j-1];
          hist[exp_g][0] = bus.in_data[exp_g*DW +: DW];
          rr_m = exp_g;
          cur_m = exp_g;
          busy_cnt = TAPS + 1;
          pend_data = AW'(filt(exp_g));
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_sample(input int ch, input logic [DW-1:0] v);
    bus.in_data[ch*DW +: DW] = v;
  endtask

  task automatic wait_ready(input int ch, input string name);
    bit found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (obs_rdy[ch]) found = 1;
    end
    chk(name, 64'(found), 64'(1));
  endtask

  task automatic wait_ov(input string name);
    bit found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (obs_ov) found = 1;
    end
    chk(name, 64'(found), 64'(1));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    steps(2);
    reset = 1'b0;
  endtask

  task automatic program_coefs(input int mode);
    bus.coef_we = 1'b1;
    for (int k = 0; k < TAPS; k++) begin
      bus.coef_addr = CNT_W'(k);
      bus.coef_data = (mode == 0) ? DW'(k + 1) : DW'(1);
      step();
    end
    bus.coef_we = 1'b0;
  endtask

  typedef struct {
    logic [DW-1:0] sample;
    logic [AW-1:0] exp_out;
    int            exp_ch;
  } vec_t;

  vec_t vecs [TAPS];
  int g_cyc[$], g_ch[$], first_c[$], last_c[$], ov_c[$];
  logic [DW-1:0] coeff_seq[$];
  int n_rdy, n_mac;

  initial begin
    for (int i = 0; i < TAPS; i++) begin
      vecs[i].sample  = (i == 0) ? DW'(1) : DW'(0);
      vecs[i].exp_out = AW'(i + 1);
      vecs[i].exp_ch  = 0;
    end

    reset = 1'b1; clk_enable = 1'b1;
    bus.in_valid = '0; bus.in_data = '0; bus.coef_we = 1'b0;
    bus.coef_addr = '0; bus.coef_data = '0; bus.out_ready = 1'b1;
    model_reset();
    @(negedge clk);
    do_reset();
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_out_data", 64'(bus.out_data), 64'(0));
    chk("rst_out_ch", 64'(bus.out_ch), 64'(0));
    chk("rst_mac_valid", 64'(bus.mac_valid), 64'(0));
    chk("rst_coef_busy", 64'(bus.coef_busy), 64'(0));

    // Impulse response through the table
    program_coefs(0);
    for (int i = 0; i < TAPS; i++) begin
      set_sample(0, vecs[i].sample);
      bus.in_valid = 2'b01;
      wait_ready(0, "imp_accept");
      bus.in_valid = '0;
      wait_ov("imp_out_valid");
      chk("imp_out_data", 64'(obs_data), 64'(vecs[i].exp_out));
      chk("imp_out_ch", 64'(obs_ch), 64'(vecs[i].exp_ch));
    end
    steps(2);

    // Both channels requesting: alternation, period and latency
    do_reset();
    program_coefs(0);
    set_sample(0, 16'd3); set_sample(1, 16'd5);
    bus.in_valid = 2'b11;
    for (int i = 0; i < 32; i++) begin
      step();
      if (obs_rdy != '0) begin
        g_cyc.push_back(cyc);
        g_ch.push_back(obs_rdy[1] ? 1 : 0);
        chk("gr_onehot", 64'($countones(obs_rdy)), 64'(1));
      end
      if (obs_first) first_c.push_back(cyc);
      if (obs_last) last_c.push_back(cyc);
      if (obs_ov) ov_c.push_back(cyc);
      if (obs_mac && g_cyc.size() == 1) coeff_seq.push_back(obs_coeff);
    end
    chk("gr_count", 64'(g_cyc.size() >= 3), 64'(1));
    while (g_cyc.size() < 3) begin g_cyc.push_back(-100); g_ch.push_back(-1); end
    if (first_c.size() == 0) first_c.push_back(-100);
    if (last_c.size() == 0) last_c.push_back(-100);
    if (ov_c.size() == 0) ov_c.push_back(-100);
    chk("gr_ch0", 64'(g_ch[0]), 64'(0));
    chk("gr_ch1", 64'(g_ch[1]), 64'(1));
    chk("gr_ch2", 64'(g_ch[2]), 64'(0));
    chk("gr_period1", 64'(g_cyc[1] - g_cyc[0]), 64'(10));
    chk("gr_period2", 64'(g_cyc[2] - g_cyc[1]), 64'(10));
    chk("lat_first", 64'(first_c[0] - g_cyc[0]), 64'(1));
    chk("lat_last", 64'(last_c[0] - g_cyc[0]), 64'(8));
    chk("lat_out_valid", 64'(ov_c[0] - g_cyc[0]), 64'(10));
    chk("coeff_walk_len", 64'(coeff_seq.size()), 64'(TAPS));
    for (int k = 0; k < coeff_seq.size() && k < TAPS; k++)
      chk("coeff_walk", 64'(coeff_seq[k]), 64'(k + 1));

    // Back-pressure with requests pending
    bus.out_ready = 1'b0;
    steps(12);
    n_rdy = 0; n_mac = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (obs_rdy != '0) n_rdy++;
      if (obs_mac) n_mac++;
    end
    chk("bp_in_ready", 64'(n_rdy), 64'(0));
    chk("bp_mac", 64'(n_mac), 64'(0));
    chk("bp_held_valid", 64'(obs_ov), 64'(1));
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = '0;
    steps(12);

    // Coefficient write while busy is dropped
    set_sample(0, 16'd7);
    bus.in_valid = 2'b01;
    wait_ready(0, "cb_accept");
    bus.in_valid = '0;
    steps(3);
    bus.coef_we = 1'b1; bus.coef_addr = 3'd0; bus.coef_data = 16'h7777;
    step();
    chk("cb_busy", 64'(obs_busy), 64'(1));
    chk("cb_tap3", 64'(obs_coeff), 64'(4));
    bus.coef_we = 1'b0;
    wait_ov("cb_out_valid");
    // Write in IDLE with a request: write wins, accept next cycle
    bus.coef_we = 1'b1; bus.coef_addr = 3'd2; bus.coef_data = 16'h0100;
    bus.in_valid = 2'b01;
    step();
    chk("cw_no_accept", 64'(obs_rdy), 64'(0));
    bus.coef_we = 1'b0;
    step();
    chk("cw_accept", 64'(obs_rdy), 64'(1));
    bus.in_valid = '0;
    step();
    chk("cw_coef0_kept", 64'(obs_coeff), 64'(1));
    steps(2);
    chk("cw_coef2_new", 64'(obs_coeff), 64'(16'h0100));
    wait_ov("cw_out_valid");

    // Reset in the middle of a sample
    set_sample(1, 16'h1111);
    bus.in_valid = 2'b10;
    wait_ready(1, "rr_accept");
    bus.in_valid = '0;
    steps(5);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mr_busy", 64'(bus.coef_busy), 64'(0));
    chk("mr_out_valid", 64'(bus.out_valid), 64'(0));
    chk("mr_mac_valid", 64'(bus.mac_valid), 64'(0));
    set_sample(0, 16'h1234);
    bus.in_valid = 2'b01;
    wait_ready(0, "mr_accept0");
    bus.in_valid = '0;
    wait_ov("mr_ov0");
    chk("mr_coef_zero", 64'(obs_data), 64'(0));
    program_coefs(1);
    set_sample(1, 16'h0000);
    bus.in_valid = 2'b10;
    wait_ready(1, "mr_accept1");
    bus.in_valid = '0;
    wait_ov("mr_ov1");
    chk("mr_line_zero", 64'(obs_data), 64'(0));

    // clk_enable low freezes the tap counter
    set_sample(0, 16'd2);
    bus.in_valid = 2'b01;
    wait_ready(0, "ce_accept");
    steps(3);
    clk_enable = 1'b0;
    bus.in_valid = 2'b11;
    n_rdy = 0; n_mac = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (obs_rdy != '0) n_rdy++;
      if (obs_mac) n_mac++;
    end
    chk("ce_in_ready", 64'(n_rdy), 64'(0));
    chk("ce_mac", 64'(n_mac), 64'(0));
    clk_enable = 1'b1;
    bus.in_valid = '0;
    n_mac = 0;
    for (int i = 0; i < 20 && !obs_ov; i++) begin
      step();
      if (obs_mac) n_mac++;
    end
    chk("ce_remaining_taps", 64'(n_mac), 64'(5));
    steps(2);

    // Random traffic against the reference model
    program_coefs(0);
    n_hs = 0;
    for (int i = 0; i < 1500; i++) begin
      bus.in_valid  = N_CH'($urandom_range(0, 3));
      set_sample(0, DW'($urandom));
      set_sample(1, DW'($urandom));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      clk_enable    = ($urandom_range(0, 9) != 0);
      bus.coef_we   = ($urandom_range(0, 15) == 0);
      bus.coef_addr = CNT_W'($urandom_range(0, TAPS - 1));
      bus.coef_data = DW'($urandom);
      step();
    end
    bus.in_valid = '0; bus.coef_we = 1'b0; bus.out_ready = 1'b1; clk_enable = 1'b1;
    steps(15);
    chk("rand_results", 64'(n_hs > 20), 64'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
